// File: rtl/rf_seq_defs_pkg.sv
// Shared definitions for the register-file sequencer: state encoding, instruction
// opcode/op constants, writeback source codes and the decoded instruction class.
package rf_seq_defs;

  typedef enum logic [2:0] {
    ST_WAIT      = 3'd0,
    ST_DECODE    = 3'd1,
    ST_WRITE_IMM = 3'd2,
    ST_GET_A     = 3'd3,
    ST_GET_B     = 3'd4,
    ST_ALU       = 3'd5,
    ST_WRITE_REG = 3'd6
  } state_e;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [1:0] VSEL_C   = 2'd0;
  localparam logic [1:0] VSEL_IMM = 2'd2;

  // Instruction class flags; two_op covers ADD/CMP/AND, which read both Rn and Rm.
  typedef struct packed {
    logic mov_imm;
    logic mov_reg;
    logic mvn;
    logic two_op;
    logic cmp;
  } ins_class_t;

endpackage

// File: rtl/rf_seq_ctrl_instr_dec.sv
// Combinational decode of the instruction register: field extraction, sign-extended
// imm8, ALU operation and instruction-class flags.
module instr_dec
  import rf_seq_defs::*;
#(
  parameter int DW = 16,
  parameter int RW = 3
) (
  input  logic [DW-1:0] ir_i,
  output logic [RW-1:0] rn_o,
  output logic [RW-1:0] rd_o,
  output logic [RW-1:0] rm_o,
  output logic [1:0]    sh_o,
  output logic [1:0]    alu_op_o,
  output logic [DW-1:0] sximm8_o,
  output ins_class_t    cls_o
);

  logic [2:0] opcode;
  logic [1:0] op;

  assign opcode   = ir_i[15:13];
  assign op       = ir_i[12:11];
  assign rn_o     = ir_i[8 +: RW];
  assign rd_o     = ir_i[5 +: RW];
  assign rm_o     = ir_i[0 +: RW];
  assign sh_o     = ir_i[4:3];
  assign sximm8_o = {{(DW-8){ir_i[7]}}, ir_i[7:0]};
  // MOV forms always run the ALU as a pass-through (op 00).
  assign alu_op_o = (opcode == OPC_ALU) ? op : 2'b00;

  always_comb begin
    cls_o = '0;
    if (opcode == OPC_MOV) begin
      cls_o.mov_imm = (op == OP_MOV_IMM);
      cls_o.mov_reg = (op == OP_MOV_REG);
    end else if (opcode == OPC_ALU) begin
      cls_o.mvn    = (op == OP_MVN);
      cls_o.two_op = (op != OP_MVN);
      cls_o.cmp    = (op == OP_CMP);
    end
  end

endmodule

// File: rtl/rf_seq_ctrl.sv
// Multicycle controller for the 8x16 register file and ALU datapath: holds the
// instruction register and steps each MOV/ALU instruction through read, compute, write.
module rf_seq_ctrl
  import rf_seq_defs::*;
#(
  parameter int DW = 16,
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s,
  input  logic          load,
  input  logic [DW-1:0] in,
  output logic          w,
  output logic [RW-1:0] readnum,
  output logic [RW-1:0] writenum,
  output logic          write,
  output logic          loada,
  output logic          loadb,
  output logic          loadc,
  output logic          loads,
  output logic          asel,
  output logic          bsel,
  output logic [1:0]    vsel,
  output logic [1:0]    shift,
  output logic [1:0]    ALUop,
  output logic [DW-1:0] sximm8
);

  state_e        state_q, state_d;
  logic [DW-1:0] ir_q, ir_d;

  logic          w_q;
  logic [RW-1:0] readnum_q, writenum_q;
  logic          write_q, loada_q, loadb_q, loadc_q, loads_q, asel_q;
  logic [1:0]    vsel_q, shift_q;

  logic [RW-1:0] rn, rd, rm;
  logic [1:0]    sh;
  ins_class_t    cls;

  instr_dec #(.DW(DW), .RW(RW)) u_dec (
    .ir_i     (ir_q),
    .rn_o     (rn),
    .rd_o     (rd),
    .rm_o     (rm),
    .sh_o     (sh),
    .alu_op_o (ALUop),
    .sximm8_o (sximm8),
    .cls_o    (cls)
  );

  // The IR only accepts a new word while idle, so fields are stable for a whole sequence.
  assign ir_d = (state_q == ST_WAIT && load) ? in : ir_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_WAIT:      if (s) state_d = ST_DECODE;
      ST_DECODE: begin
        if (cls.mov_imm)                 state_d = ST_WRITE_IMM;
        else if (cls.mov_reg || cls.mvn) state_d = ST_GET_B;
        else if (cls.two_op)             state_d = ST_GET_A;
        else                             state_d = ST_WAIT;
      end
      ST_WRITE_IMM: state_d = ST_WAIT;
      ST_GET_A:     state_d = ST_GET_B;
      ST_GET_B:     state_d = ST_ALU;
      ST_ALU:       state_d = cls.cmp ? ST_WAIT : ST_WRITE_REG;
      ST_WRITE_REG: state_d = ST_WAIT;
      default:      state_d = ST_WAIT;
    endcase
  end

  // Outputs are registered from the next state. Any state_d that uses IR fields is
  // reached from a non-WAIT state, so ir_q already holds the instruction being run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_WAIT;
      ir_q       <= '0;
      w_q        <= 1'b1;
      readnum_q  <= '0;
      writenum_q <= '0;
      write_q    <= 1'b0;
      loada_q    <= 1'b0;
      loadb_q    <= 1'b0;
      loadc_q    <= 1'b0;
      loads_q    <= 1'b0;
      asel_q     <= 1'b0;
      vsel_q     <= VSEL_C;
      shift_q    <= 2'b00;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      w_q        <= (state_d == ST_WAIT);
      readnum_q  <= (state_d == ST_GET_A) ? rn :
                    (state_d == ST_GET_B) ? rm : '0;
      writenum_q <= (state_d == ST_WRITE_IMM) ? rn :
                    (state_d == ST_WRITE_REG) ? rd : '0;
      write_q    <= (state_d == ST_WRITE_IMM) || (state_d == ST_WRITE_REG);
      loada_q    <= (state_d == ST_GET_A);
      loadb_q    <= (state_d == ST_GET_B);
      loadc_q    <= (state_d == ST_ALU) && !cls.cmp;
      loads_q    <= (state_d == ST_ALU) && cls.cmp;
      asel_q     <= (state_d == ST_ALU) && (cls.mov_reg || cls.mvn);
      vsel_q     <= (state_d == ST_WRITE_IMM) ? VSEL_IMM : VSEL_C;
      shift_q    <= (state_d == ST_GET_B || state_d == ST_ALU) ? sh : 2'b00;
    end
  end

  assign w        = w_q;
  assign readnum  = readnum_q;
  assign writenum = writenum_q;
  assign write    = write_q;
  assign loada    = loada_q;
  assign loadb    = loadb_q;
  assign loadc    = loadc_q;
  assign loads    = loads_q;
  assign asel     = asel_q;
  assign bsel     = 1'b0;
  assign vsel     = vsel_q;
  assign shift    = shift_q;

endmodule
